// File: rtl/pkt_classifier_pkg.sv
// Shared constants, field offsets and enums for the first-beat packet classifier.
package pkt_classifier_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0008;
    localparam logic [15:0] ETH_TYPE_VLAN = 16'h0081;
    localparam logic [7:0]  IPPROT_UDP    = 8'h11;

    // Untagged field offsets in beat 0; an 802.1Q tag shifts them all up by VLAN_SHIFT.
    localparam int unsigned ETH_TYPE_LO  = 128;
    localparam int unsigned IP_PROT_LO   = 216;
    localparam int unsigned UDP_DPORT_LO = 320;
    localparam int unsigned VLAN_SHIFT   = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFwdData = 2'd1,
        StFwdCtl  = 2'd2,
        StDrop    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ClsData,
        ClsCtl,
        ClsDrop
    } pkt_class_t;

    function automatic state_t class_to_state(input pkt_class_t cls);
        state_t st;
        unique case (cls)
            ClsData: st = StFwdData;
            ClsCtl:  st = StFwdCtl;
            default: st = StDrop;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/axis_out_slot.sv
// One-entry AXI-Stream output register; free means a beat can be loaded this cycle.
module axis_out_slot #(
    parameter int unsigned DW = 512,
    parameter int unsigned UW = 128
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            load,
    input  logic [DW-1:0]   in_tdata,
    input  logic [DW/8-1:0] in_tkeep,
    input  logic [UW-1:0]   in_tuser,
    input  logic            in_tlast,
    output logic [DW-1:0]   tdata,
    output logic [DW/8-1:0] tkeep,
    output logic [UW-1:0]   tuser,
    output logic            tlast,
    output logic            tvalid,
    input  logic            tready,
    output logic            free
);

    assign free = !tvalid || tready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            tdata  <= '0;
            tkeep  <= '0;
            tuser  <= '0;
            tlast  <= 1'b0;
            tvalid <= 1'b0;
        end else if (load) begin
            tdata  <= in_tdata;
            tkeep  <= in_tkeep;
            tuser  <= in_tuser;
            tlast  <= in_tlast;
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/pkt_classifier.sv
// First-beat IPv4/UDP classifier steering packets to data, control or drop.
// Optional 802.1Q tag parsing is enabled by defining PKT_CLASSIFIER_VLAN_EN.
module pkt_classifier
    import pkt_classifier_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_NUM_CTRL_PORTS     = 2,
    parameter int unsigned C_CNT_WIDTH          = 32
) (
    input  logic                                clk,
    input  logic                                aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]      c_m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]    c_m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]     c_m_axis_tuser,
    output logic                                c_m_axis_tvalid,
    input  logic                                c_m_axis_tready,
    output logic                                c_m_axis_tlast,
    input  logic [16*C_NUM_CTRL_PORTS-1:0]      ctrl_ports,
    input  logic [C_NUM_CTRL_PORTS-1:0]         ctrl_port_en,
    output logic [C_CNT_WIDTH-1:0]              cnt_data,
    output logic [C_CNT_WIDTH-1:0]              cnt_ctrl,
    output logic [C_CNT_WIDTH-1:0]              cnt_drop
);

    state_t     state;
    pkt_class_t cls;
    logic       ready_en;
    logic       rdy;
    logic       data_free;
    logic       ctrl_free;
    logic       accept;
    logic       load_data;
    logic       load_ctrl;
    logic       port_hit;
    logic [15:0] eth_type;
    logic [15:0] dport;
    logic [7:0]  ip_prot;

    function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        eth_type = s_axis_tdata[ETH_TYPE_LO +: 16];
        ip_prot  = s_axis_tdata[IP_PROT_LO +: 8];
        dport    = s_axis_tdata[UDP_DPORT_LO +: 16];
`ifdef PKT_CLASSIFIER_VLAN_EN
        if (eth_type == ETH_TYPE_VLAN) begin
            eth_type = s_axis_tdata[ETH_TYPE_LO + VLAN_SHIFT +: 16];
            ip_prot  = s_axis_tdata[IP_PROT_LO + VLAN_SHIFT +: 8];
            dport    = s_axis_tdata[UDP_DPORT_LO + VLAN_SHIFT +: 16];
        end
`endif
        port_hit = 1'b0;
        for (int unsigned i = 0; i < C_NUM_CTRL_PORTS; i++) begin
            if (ctrl_port_en[i] && (ctrl_ports[16*i +: 16] == dport)) begin
                port_hit = 1'b1;
            end
        end
        if (eth_type == ETH_TYPE_IPV4 && ip_prot == IPPROT_UDP) begin
            cls = port_hit ? ClsCtl : ClsData;
        end else begin
            cls = ClsDrop;
        end
    end

    // ready_en keeps s_axis_tready low while in reset and for the first cycle after.
    always_comb begin
        rdy = 1'b0;
        unique case (state)
            StIdle:    rdy = data_free && ctrl_free;
            StFwdData: rdy = data_free;
            StFwdCtl:  rdy = ctrl_free;
            StDrop:    rdy = 1'b1;
            default:   rdy = 1'b0;
        endcase
        s_axis_tready = ready_en && rdy;
    end

    assign accept    = s_axis_tvalid && s_axis_tready;
    assign load_data = accept && (state == StFwdData || (state == StIdle && cls == ClsData));
    assign load_ctrl = accept && (state == StFwdCtl || (state == StIdle && cls == ClsCtl));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= StIdle;
            ready_en <= 1'b0;
            cnt_data <= '0;
            cnt_ctrl <= '0;
            cnt_drop <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                if (state == StIdle) begin
                    unique case (cls)
                        ClsData: cnt_data <= sat_inc(cnt_data);
                        ClsCtl:  cnt_ctrl <= sat_inc(cnt_ctrl);
                        default: cnt_drop <= sat_inc(cnt_drop);
                    endcase
                    if (!s_axis_tlast) begin
                        state <= class_to_state(cls);
                    end
                end else if (s_axis_tlast) begin
                    state <= StIdle;
                end
            end
        end
    end

    axis_out_slot #(
        .DW (C_S_AXIS_DATA_WIDTH),
        .UW (C_S_AXIS_TUSER_WIDTH)
    ) u_data_slot (
        .clk      (clk),
        .aresetn  (aresetn),
        .load     (load_data),
        .in_tdata (s_axis_tdata),
        .in_tkeep (s_axis_tkeep),
        .in_tuser (s_axis_tuser),
        .in_tlast (s_axis_tlast),
        .tdata    (m_axis_tdata),
        .tkeep    (m_axis_tkeep),
        .tuser    (m_axis_tuser),
        .tlast    (m_axis_tlast),
        .tvalid   (m_axis_tvalid),
        .tready   (m_axis_tready),
        .free     (data_free)
    );

    axis_out_slot #(
        .DW (C_S_AXIS_DATA_WIDTH),
        .UW (C_S_AXIS_TUSER_WIDTH)
    ) u_ctrl_slot (
        .clk      (clk),
        .aresetn  (aresetn),
        .load     (load_ctrl),
        .in_tdata (s_axis_tdata),
        .in_tkeep (s_axis_tkeep),
        .in_tuser (s_axis_tuser),
        .in_tlast (s_axis_tlast),
        .tdata    (c_m_axis_tdata),
        .tkeep    (c_m_axis_tkeep),
        .tuser    (c_m_axis_tuser),
        .tlast    (c_m_axis_tlast),
        .tvalid   (c_m_axis_tvalid),
        .tready   (c_m_axis_tready),
        .free     (ctrl_free)
    );

endmodule

// File: tb/tb_pkt_classifier.sv
// Directed bench for pkt_classifier; expectations follow PKT_CLASSIFIER_VLAN_EN if defined.
module tb_pkt_classifier;

    localparam int unsigned DW = 512;
    localparam int unsigned UW = 128;
    localparam int unsigned NP = 2;
    localparam int unsigned CW = 32;

    logic            clk;
    logic            aresetn;
    logic [DW-1:0]   s_axis_tdata;
    logic [DW/8-1:0] s_axis_tkeep;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic            m_axis_tlast;
    logic [DW-1:0]   c_m_axis_tdata;
    logic [DW/8-1:0] c_m_axis_tkeep;
    logic [UW-1:0]   c_m_axis_tuser;
    logic            c_m_axis_tvalid;
    logic            c_m_axis_tready;
    logic            c_m_axis_tlast;
    logic [16*NP-1:0] ctrl_ports;
    logic [NP-1:0]    ctrl_port_en;
    logic [CW-1:0]    cnt_data;
    logic [CW-1:0]    cnt_ctrl;
    logic [CW-1:0]    cnt_drop;

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] m_q[$];
    logic [32:0] c_q[$];

    pkt_classifier #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .C_NUM_CTRL_PORTS     (NP),
        .C_CNT_WIDTH          (CW)
    ) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .c_m_axis_tdata  (c_m_axis_tdata),
        .c_m_axis_tkeep  (c_m_axis_tkeep),
        .c_m_axis_tuser  (c_m_axis_tuser),
        .c_m_axis_tvalid (c_m_axis_tvalid),
        .c_m_axis_tready (c_m_axis_tready),
        .c_m_axis_tlast  (c_m_axis_tlast),
        .ctrl_ports      (ctrl_ports),
        .ctrl_port_en    (ctrl_port_en),
        .cnt_data        (cnt_data),
        .cnt_ctrl        (cnt_ctrl),
        .cnt_drop        (cnt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each transfer as {tlast, beat id}; inputs settle by negedge+1.
    always @(negedge clk) begin
        #2;
        if (m_axis_tvalid && m_axis_tready) m_q.push_back({m_axis_tlast, m_axis_tdata[31:0]});
        if (c_m_axis_tvalid && c_m_axis_tready) c_q.push_back({c_m_axis_tlast, c_m_axis_tdata[31:0]});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr(input logic [15:0] eth, input logic [7:0] prot,
                                          input logic [15:0] dp, input logic [31:0] id);
        logic [DW-1:0] d;
        d = '0;
        d[143:128] = eth;
        d[223:216] = prot;
        d[335:320] = dp;
        d[31:0]    = id;
        return d;
    endfunction

    function automatic logic [DW-1:0] vlan_hdr(input logic [15:0] dp, input logic [31:0] id);
        logic [DW-1:0] d;
        d = '0;
        d[143:128] = 16'h0081;
        d[159:144] = 16'h0500;
        d[175:160] = 16'h0008;
        d[255:248] = 8'h11;
        d[367:352] = dp;
        d[31:0]    = id;
        return d;
    endfunction

    function automatic logic [DW-1:0] pl(input logic [31:0] id);
        logic [DW-1:0] d;
        d = '0;
        d[31:0] = id;
        return d;
    endfunction

    // Drive one beat from a negedge; returns at the negedge after it was accepted.
    task automatic send(input logic [DW-1:0] d, input logic last, output int waits);
        waits = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && waits < 100) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (waits >= 100) begin
            n_cmp++;
            n_err++;
            $error("FAIL send_timeout: observed tready 0 expected 1");
        end
        @(posedge clk);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int w;
        int tot;
        aresetn         = 1'b0;
        s_axis_tdata    = '0;
        s_axis_tkeep    = '1;
        s_axis_tuser    = '0;
        s_axis_tvalid   = 1'b0;
        s_axis_tlast    = 1'b0;
        m_axis_tready   = 1'b1;
        c_m_axis_tready = 1'b1;
        ctrl_ports      = {16'hf2f1, 16'hf2f2};
        ctrl_port_en    = 2'b11;

        // Reset state
        idle(2);
        #1;
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_c_tvalid", c_m_axis_tvalid, 0);
        chk("rst_m_tdata", m_axis_tdata[63:0], 0);
        chk("rst_cnt_data", cnt_data, 0);
        chk("rst_cnt_ctrl", cnt_ctrl, 0);
        chk("rst_cnt_drop", cnt_drop, 0);
        @(negedge clk);
        aresetn = 1'b1;
        idle(1);
        #1;
        chk("post_rst_tready", s_axis_tready, 1);
        @(negedge clk);

        // 3-beat data packet
        send(hdr(16'h0008, 8'h11, 16'h1234, 32'h1), 1'b0, w);
        send(pl(32'h2), 1'b0, w);
        send(pl(32'h3), 1'b1, w);
        idle(3);
        chk("t1_m_count", m_q.size(), 3);
        chk("t1_m_beat0", m_q[0], {1'b0, 32'h1});
        chk("t1_m_beat1", m_q[1], {1'b0, 32'h2});
        chk("t1_m_beat2", m_q[2], {1'b1, 32'h3});
        chk("t1_c_count", c_q.size(), 0);
        chk("t1_cnt_data", cnt_data, 1);
        m_q.delete();
        c_q.delete();

        // Control packet on slot 0 (16'hf2f2)
        send(hdr(16'h0008, 8'h11, 16'hf2f2, 32'h10), 1'b0, w);
        send(pl(32'h11), 1'b1, w);
        idle(3);
        chk("t2_c_count", c_q.size(), 2);
        chk("t2_c_beat0", c_q[0], {1'b0, 32'h10});
        chk("t2_c_beat1", c_q[1], {1'b1, 32'h11});
        chk("t2_m_count", m_q.size(), 0);
        chk("t2_cnt_ctrl", cnt_ctrl, 1);
        m_q.delete();
        c_q.delete();

        // Same port with its slot disabled; enable change mid-packet is ignored
        ctrl_port_en = 2'b10;
        send(hdr(16'h0008, 8'h11, 16'hf2f2, 32'h20), 1'b0, w);
        ctrl_port_en = 2'b11;
        send(pl(32'h21), 1'b1, w);
        idle(3);
        chk("t2b_m_count", m_q.size(), 2);
        chk("t2b_m_beat1", m_q[1], {1'b1, 32'h21});
        chk("t2b_c_count", c_q.size(), 0);
        chk("t2b_cnt_data", cnt_data, 2);
        chk("t2b_cnt_ctrl", cnt_ctrl, 1);
        m_q.delete();
        c_q.delete();

        // ARP drop, then a UDP packet immediately behind it
        tot = 0;
        send(hdr(16'h0608, 8'h11, 16'h1234, 32'h30), 1'b0, w);
        tot += w;
        send(pl(32'h31), 1'b0, w);
        tot += w;
        send(pl(32'h32), 1'b0, w);
        tot += w;
        send(pl(32'h33), 1'b1, w);
        tot += w;
        send(hdr(16'h0008, 8'h11, 16'h1234, 32'h40), 1'b1, w);
        tot += w;
        #1;
        chk("t3_next_valid", m_axis_tvalid, 1);
        chk("t3_next_id", m_axis_tdata[31:0], 32'h40);
        chk("t3_no_stall", tot, 0);
        idle(3);
        chk("t3_cnt_drop", cnt_drop, 1);
        chk("t3_cnt_data", cnt_data, 3);
        chk("t3_m_count", m_q.size(), 1);
        chk("t3_c_count", c_q.size(), 0);
        m_q.delete();
        c_q.delete();

        // Control path stalled for 5 cycles
        c_m_axis_tready = 1'b0;
        send(hdr(16'h0008, 8'h11, 16'hf2f1, 32'h50), 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_stall_tready", s_axis_tready, 0);
            chk("t4_stall_cvalid", c_m_axis_tvalid, 1);
            @(negedge clk);
        end
        c_m_axis_tready = 1'b1;
        send(pl(32'h51), 1'b0, w);
        send(pl(32'h52), 1'b1, w);
        idle(3);
        chk("t4_c_count", c_q.size(), 3);
        chk("t4_c_beat0", c_q[0], {1'b0, 32'h50});
        chk("t4_c_beat1", c_q[1], {1'b0, 32'h51});
        chk("t4_c_beat2", c_q[2], {1'b1, 32'h52});
        chk("t4_cnt_data", cnt_data, 3);
        chk("t4_cnt_ctrl", cnt_ctrl, 2);
        m_q.delete();
        c_q.delete();

        // Single-beat packet followed back-to-back by a 2-beat data packet
        tot = 0;
        send(hdr(16'h0008, 8'h11, 16'h1234, 32'h60), 1'b1, w);
        tot += w;
        #1;
        chk("t5_lat_id0", m_axis_tdata[31:0], 32'h60);
        send(hdr(16'h0008, 8'h11, 16'h1234, 32'h61), 1'b0, w);
        tot += w;
        #1;
        chk("t5_lat_id1", m_axis_tdata[31:0], 32'h61);
        send(pl(32'h62), 1'b1, w);
        tot += w;
        idle(3);
        chk("t5_no_stall", tot, 0);
        chk("t5_m_count", m_q.size(), 3);
        chk("t5_m_beat0", m_q[0], {1'b1, 32'h60});
        chk("t5_m_beat1", m_q[1], {1'b0, 32'h61});
        chk("t5_m_beat2", m_q[2], {1'b1, 32'h62});
        chk("t5_cnt_data", cnt_data, 5);
        m_q.delete();
        c_q.delete();

        // 802.1Q-tagged UDP frame to a control port
        send(vlan_hdr(16'hf2f1, 32'h70), 1'b0, w);
        send(pl(32'h71), 1'b1, w);
        idle(3);
`ifdef PKT_CLASSIFIER_VLAN_EN
        chk("t6_c_count", c_q.size(), 2);
        chk("t6_cnt_ctrl", cnt_ctrl, 3);
        chk("t6_cnt_drop", cnt_drop, 1);
`else
        chk("t6_c_count", c_q.size(), 0);
        chk("t6_cnt_ctrl", cnt_ctrl, 2);
        chk("t6_cnt_drop", cnt_drop, 2);
`endif
        chk("t6_m_count", m_q.size(), 0);
        m_q.delete();
        c_q.delete();

        // Reset mid-packet; the remainder is then seen as a new (non-IPv4) beat 0
        m_axis_tready = 1'b0;
        send(hdr(16'h0008, 8'h11, 16'h1234, 32'h80), 1'b0, w);
        aresetn = 1'b0;
        #1;
        chk("t7_m_valid", m_axis_tvalid, 0);
        chk("t7_cnt_data", cnt_data, 0);
        chk("t7_cnt_ctrl", cnt_ctrl, 0);
        chk("t7_tready", s_axis_tready, 0);
        @(negedge clk);
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        send(pl(32'h81), 1'b1, w);
        idle(3);
        chk("t7_cnt_drop", cnt_drop, 1);
        chk("t7_m_count", m_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
